issue_controller: RTL and testbench
===================================

Name: issue_controller

Overview:
- In-order issue and sequencing controller for the 8-bit, 8-register datapath.
- Accepts decoded instructions over a valid/ready handshake and steps them through EX (single-cycle ALU, or a variable-latency memory load) and WB.
- Drives the ALU op select, memory request handshake, writeback controls and WB-to-EX operand forwarding selects.
- Sits between the decoder and the ALU/register-file/memory datapath.

Parameters:
- STALL_W, 8, width of the saturating stall-cycle counter.
- TIMEOUT, 16, max EX cycles a load waits for mem_ack (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  decoder presents an instruction
- in_ready  output  1  controller accepts this cycle
- in_op  input  2  00 MOV (result=A), 01 ADD (A+B), 10 LOAD, 11 NOP
- in_rs1  input  3  source register 1
- in_rs2  input  3  source register 2
- in_rd  input  3  destination register
- in_regwrite  input  1  instruction writes rd
- ex_valid  output  1  EX stage holds an instruction
- ex_aluop  output  1  ALU select: 0 pass A, 1 A+B
- ex_rs1, ex_rs2, ex_rd  output  3 each  EX-stage register fields
- fwd_rs1, fwd_rs2  output  1 each  select WB result instead of register-file read for the EX operand
- mem_req  output  1  load request, address = EX operand A
- mem_ack  input  1  load data valid this cycle
- wb_valid  output  1  WB stage holds an instruction
- wb_we  output  1  register-file write enable, end of this cycle
- wb_rd  output  3  write address
- wb_sel  output  1  0 ALU result, 1 memory data
- stall_cycles  output  STALL_W  cycles with in_valid=1 and in_ready=0, saturating
- mem_err  output  1  load timeout flag (MEM_TIMEOUT_EN only, otherwise tied 0)

Behaviour:
- Reset values: all outputs 0, except in_ready, which follows its combinational rule and is therefore 1 while EX is empty.
- Pipeline: handshake (in_valid & in_ready) at edge N loads the EX register; ex_valid=1 in cycle N+1.
- ALU ops and NOP leave EX after exactly one cycle and enter WB; WB lasts exactly one cycle.
- in_ready (combinational) = !ex_valid | (ex is not LOAD) | (ex is LOAD & mem_ack).
  - ALU ops therefore issue back-to-back at 1 per cycle.
  - EX advances into WB whenever it completes, even if no new instruction arrives; WB is always drained.
- LOAD:
  - mem_req=1 every EX cycle until mem_ack, which may arrive in the first EX cycle or any later cycle.
  - mem_req drops the cycle after ack.
  - On ack the load moves to WB with wb_sel=1. The datapath captures memory data into the WB register.
  - mem_ack while no load is in EX is ignored.
- NOP: passes through EX/WB with wb_we=0 regardless of in_regwrite.
- MOV/ADD: ex_aluop = in_op[0]; wb_sel=0.
- wb_we = wb_valid & regwrite of the WB instruction.
- Forwarding: fwd_rs1 = ex_valid & wb_we & (wb_rd==ex_rs1); fwd_rs2 likewise for ex_rs2.
  - Both may assert together.
  - Forwarding applies to ALU and LOAD producers alike.
  - An instruction accepted while a load sits in EX waits in the decoder; once accepted it reaches EX with the load in WB, so it is always covered by forwarding and no scoreboard is needed.
- Register-file write and read of the same register in one cycle: forwarding covers it; no read-after-write bypass is needed in the register file.
- stall_cycles increments by 1 per stalled cycle, holds at all-ones, clears only on rst.
- Reset mid-load: EX and WB are invalidated on the reset edge, mem_req=0 the next cycle, and a late mem_ack is ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined: an internal counter runs while a load waits in EX.
  - After TIMEOUT cycles with no mem_ack, the load is aborted: it moves to WB with wb_we=0 and wb_sel=1, mem_req drops, and mem_err is set.
  - mem_err is sticky until rst.
  - mem_ack on the same cycle the count expires counts as success.
- Not defined: a load waits indefinitely, no counter is present, and mem_err is constant 0.

Test Plan:
- Reset, then stream ADD r1 (rd=1,rs=2,3), MOV r4←r1, ADD r5=r1+r1 -> in_ready constant 1, one instruction per cycle.
  - MOV in EX: fwd_rs1=1.
  - ADD r5 in EX: fwd_rs1=0, fwd_rs2=0, because r1 is already written.
- ADD rd=2, then ADD rs1=2, rs2=2 back-to-back -> second instruction in EX: fwd_rs1=1, fwd_rs2=1, ex_aluop=1; wb_rd=2, wb_we=1 that cycle.
- LOAD rd=3 with mem_ack after 4 cycles, then ADD rs1=3 held on in_valid -> mem_req high 4 cycles, in_ready=0 and stall_cycles+1 on each of the first 3 of those cycles.
  - ADD accepted on the ack cycle (in_ready=1 then).
  - Load WB: wb_sel=1. ADD in EX the same cycle: fwd_rs1=1.
- NOP with in_regwrite=1, rd=0 followed by MOV rs1=0 -> NOP WB: wb_we=0; MOV fwd_rs1=0.
- rst asserted during a LOAD wait, mem_ack pulsed 2 cycles later -> mem_req=0 and ex_valid=0 after the reset edge, wb_valid stays 0, stall_cycles=0.
- MEM_TIMEOUT_EN, TIMEOUT=16, LOAD never acked -> mem_req high 16 cycles, then wb_valid=1 with wb_we=0; mem_err=1 and sticky; the next instruction is accepted on the abort cycle.

Source files
------------

// File: rtl/issue_controller.sv
// In-order issue/sequencing controller: decoder handshake, EX (ALU or load), WB, forwarding.
// Optional build macro MEM_TIMEOUT_EN aborts loads that wait TIMEOUT EX cycles without mem_ack.
module issue_controller #(
    parameter int STALL_W = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [2:0]         in_rs1,
    input  logic [2:0]         in_rs2,
    input  logic [2:0]         in_rd,
    input  logic               in_regwrite,
    output logic               ex_valid,
    output logic               ex_aluop,
    output logic [2:0]         ex_rs1,
    output logic [2:0]         ex_rs2,
    output logic [2:0]         ex_rd,
    output logic               fwd_rs1,
    output logic               fwd_rs2,
    output logic               mem_req,
    input  logic               mem_ack,
    output logic               wb_valid,
    output logic               wb_we,
    output logic [2:0]         wb_rd,
    output logic               wb_sel,
    output logic [STALL_W-1:0] stall_cycles,
    output logic               mem_err
);

    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;
    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
    localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

    logic               ex_valid_r;
    logic [1:0]         ex_op_r;
    logic [2:0]         ex_rs1_r;
    logic [2:0]         ex_rs2_r;
    logic [2:0]         ex_rd_r;
    logic               ex_wr_r;
    logic               wb_valid_r;
    logic               wb_wr_r;
    logic [2:0]         wb_rd_r;
    logic               wb_sel_r;
    logic [STALL_W-1:0] stall_r;

    logic ex_is_load_s;
    logic expire_s;
    logic ex_done_s;
    logic accept_s;
    logic wb_we_s;

    assign ex_is_load_s = ex_valid_r & (ex_op_r == OP_LOAD);
    assign ex_done_s    = ex_valid_r & (~ex_is_load_s | mem_ack | expire_s);
    assign accept_s     = in_valid & in_ready;
    assign wb_we_s      = wb_valid_r & wb_wr_r;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] tmo_cnt_r;
    logic             mem_err_r;

    // An ack arriving on the expiry cycle wins, so expiry is gated by ~mem_ack.
    assign expire_s = ex_is_load_s & ~mem_ack & (tmo_cnt_r == CNT_LAST);

    // Load wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
            mem_err_r <= 1'b0;
        end else begin
            if (~ex_is_load_s | ex_done_s) begin
                tmo_cnt_r <= {CNT_W{1'b0}};
            end else begin
                tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
            end
            mem_err_r <= mem_err_r | expire_s;
        end
    end

    assign mem_err = mem_err_r;
`else
    assign expire_s = 1'b0;
    assign mem_err  = 1'b0 & (TIMEOUT > 0);
`endif

    // EX and WB pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r <= 1'b0;
            ex_op_r    <= 2'b00;
            ex_rs1_r   <= 3'b000;
            ex_rs2_r   <= 3'b000;
            ex_rd_r    <= 3'b000;
            ex_wr_r    <= 1'b0;
            wb_valid_r <= 1'b0;
            wb_wr_r    <= 1'b0;
            wb_rd_r    <= 3'b000;
            wb_sel_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                ex_valid_r <= 1'b1;
                ex_op_r    <= in_op;
                ex_rs1_r   <= in_rs1;
                ex_rs2_r   <= in_rs2;
                ex_rd_r    <= in_rd;
                ex_wr_r    <= in_regwrite & (in_op != OP_NOP);
            end else if (ex_done_s) begin
                ex_valid_r <= 1'b0;
            end
            wb_valid_r <= ex_done_s;
            if (ex_done_s) begin
                wb_wr_r  <= ex_wr_r & ~expire_s;
                wb_rd_r  <= ex_rd_r;
                wb_sel_r <= ex_is_load_s;
            end
        end
    end

    // Saturating count of cycles the decoder is held off.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_r <= {STALL_W{1'b0}};
        end else if (in_valid & ~in_ready & (stall_r != STALL_MAX)) begin
            stall_r <= stall_r + STALL_ONE;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign in_ready     = ~ex_valid_r | ex_done_s;
    assign ex_valid     = ex_valid_r;
    assign ex_aluop     = ex_valid_r & (ex_op_r == OP_ADD);
    assign ex_rs1       = ex_rs1_r;
    assign ex_rs2       = ex_rs2_r;
    assign ex_rd        = ex_rd_r;
    assign mem_req      = ex_is_load_s;
    assign wb_valid     = wb_valid_r;
    assign wb_we        = wb_we_s;
    assign wb_rd        = wb_rd_r;
    assign wb_sel       = wb_sel_r;
    assign fwd_rs1      = ex_valid_r & wb_we_s & (wb_rd_r == ex_rs1_r);
    assign fwd_rs2      = ex_valid_r & wb_we_s & (wb_rd_r == ex_rs2_r);
    assign stall_cycles = stall_r;

endmodule

// File: tb/tb_issue_controller.sv
// Bench for issue_controller: random program checked against an issue-time schedule model,
// plus directed reset-during-load, stall saturation and (with MEM_TIMEOUT_EN) timeout steps.
module tb_issue_controller;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [2:0] in_rs1;
    logic [2:0] in_rs2;
    logic [2:0] in_rd;
    logic       in_regwrite;
    logic       ex_valid;
    logic       ex_aluop;
    logic [2:0] ex_rs1;
    logic [2:0] ex_rs2;
    logic [2:0] ex_rd;
    logic       fwd_rs1;
    logic       fwd_rs2;
    logic       mem_req;
    logic       mem_ack;
    logic       wb_valid;
    logic       wb_we;
    logic [2:0] wb_rd;
    logic       wb_sel;
    logic [7:0] stall_cycles;
    logic       mem_err;

    int n_cmp = 0;
    int n_err = 0;

    issue_controller #(.STALL_W(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_regwrite(in_regwrite), .ex_valid(ex_valid), .ex_aluop(ex_aluop),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .mem_req(mem_req), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_sel(wb_sel),
        .stall_cycles(stall_cycles), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Program and its schedule: accept edge a, EX duration d, first presentation cycle p.
    localparam int N = 40;
    int op [N];
    int rs1[N];
    int rs2[N];
    int rd [N];
    int rw [N];
    int lat[N];
    int gap[N];
    int a  [N];
    int d  [N];
    int p  [N];

    initial begin
        int last_c;
        int stall_m;
        rst = 1'b1; in_valid = 1'b0; in_op = 2'b11; in_rs1 = 3'd0; in_rs2 = 3'd0;
        in_rd = 3'd0; in_regwrite = 1'b0; mem_ack = 1'b0;

        // Reset state
        next_cycle();
        @(negedge clk);
        chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
        chk("rst_ex_valid", {7'd0, ex_valid}, 8'd0);
        chk("rst_wb_valid", {7'd0, wb_valid}, 8'd0);
        chk("rst_wb_we", {7'd0, wb_we}, 8'd0);
        chk("rst_mem_req", {7'd0, mem_req}, 8'd0);
        chk("rst_stall", stall_cycles, 8'd0);
        chk("rst_mem_err", {7'd0, mem_err}, 8'd0);

        // Random program and the cycle each instruction issues/retires
        for (int i = 0; i < N; i++) begin
            op[i]  = int'($urandom_range(0, 3));
            rs1[i] = int'($urandom_range(0, 7));
            rs2[i] = int'($urandom_range(0, 7));
            rd[i]  = int'($urandom_range(0, 7));
            rw[i]  = int'($urandom_range(0, 1));
            lat[i] = int'($urandom_range(1, 5));
            gap[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            d[i]   = (op[i] == 2) ? lat[i] : 1;
            if (i == 0) begin
                p[i] = 1 + gap[i];
                a[i] = p[i];
            end else begin
                p[i] = a[i-1] + 1 + gap[i];
                a[i] = (a[i-1] + d[i-1] > p[i]) ? a[i-1] + d[i-1] : p[i];
            end
        end
        last_c = a[N-1] + d[N-1] + 3;
        stall_m = 0;

        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 1; c <= last_c; c++) begin
            int e;
            int w;
            int v;
            logic exp_ready;
            logic exp_we;
            if (c > 1) next_cycle();
            e = -1; w = -1; v = -1;
            for (int i = 0; i < N; i++) begin
                if (c >= a[i] + 1 && c <= a[i] + d[i]) e = i;
                if (c == a[i] + d[i] + 1) w = i;
                if (c >= p[i] && c <= a[i]) v = i;
            end
            in_valid = (v >= 0);
            if (v >= 0) begin
                in_op = op[v][1:0]; in_rs1 = rs1[v][2:0]; in_rs2 = rs2[v][2:0];
                in_rd = rd[v][2:0]; in_regwrite = rw[v][0];
            end else begin
                in_op = 2'(($urandom_range(0, 3))); in_regwrite = 1'b1;
            end
            if (e >= 0 && op[e] == 2) mem_ack = (c == a[e] + lat[e]);
            else mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_ready = (e < 0) || (op[e] != 2) || (c == a[e] + lat[e]);
            exp_we = (w >= 0) && (rw[w] != 0) && (op[w] != 3);
            chk("in_ready", {7'd0, in_ready}, {7'd0, exp_ready});
            chk("ex_valid", {7'd0, ex_valid}, {7'd0, (e >= 0)});
            chk("mem_req", {7'd0, mem_req}, {7'd0, (e >= 0 && op[e] == 2)});
            chk("wb_valid", {7'd0, wb_valid}, {7'd0, (w >= 0)});
            chk("wb_we", {7'd0, wb_we}, {7'd0, exp_we});
            chk("stall", stall_cycles, 8'(stall_m));
            chk("mem_err", {7'd0, mem_err}, 8'd0);
            if (e >= 0) begin
                chk("ex_rd", {5'd0, ex_rd}, 8'(rd[e]));
                chk("ex_rs1", {5'd0, ex_rs1}, 8'(rs1[e]));
                chk("ex_rs2", {5'd0, ex_rs2}, 8'(rs2[e]));
                if (op[e] < 2) chk("ex_aluop", {7'd0, ex_aluop}, 8'(op[e]));
                chk("fwd_rs1", {7'd0, fwd_rs1}, {7'd0, exp_we && rd[w] == rs1[e]});
                chk("fwd_rs2", {7'd0, fwd_rs2}, {7'd0, exp_we && rd[w] == rs2[e]});
            end
            if (w >= 0) begin
                chk("wb_rd", {5'd0, wb_rd}, 8'(rd[w]));
                chk("wb_sel", {7'd0, wb_sel}, {7'd0, (op[w] == 2)});
            end
            if (in_valid && !exp_ready && stall_m < 255) stall_m++;
        end

        // Reset while a load waits; a late ack must be ignored
        next_cycle();
        in_valid = 1'b1; in_op = 2'b10; in_rd = 3'd3; in_rs1 = 3'd1; in_regwrite = 1'b1;
        mem_ack = 1'b0;
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("rl_ex_valid", {7'd0, ex_valid}, 8'd1);
        chk("rl_mem_req", {7'd0, mem_req}, 8'd1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rl_mem_req_after", {7'd0, mem_req}, 8'd0);
        chk("rl_ex_after", {7'd0, ex_valid}, 8'd0);
        chk("rl_stall_after", stall_cycles, 8'd0);
        next_cycle();
        mem_ack = 1'b1;
        next_cycle();
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rl_wb_valid", {7'd0, wb_valid}, 8'd0);
            chk("rl_ex_valid_late", {7'd0, ex_valid}, 8'd0);
            next_cycle();
        end

`ifndef MEM_TIMEOUT_EN
        // A never-acked load with the decoder waiting saturates the stall counter
        in_valid = 1'b1; in_op = 2'b10;
        for (int k = 0; k < 300; k++) next_cycle();
        @(negedge clk);
        chk("sat_stall", stall_cycles, 8'hFF);
        chk("sat_in_ready", {7'd0, in_ready}, 8'd0);
        chk("sat_mem_req", {7'd0, mem_req}, 8'd1);
        in_valid = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
`else
        // Unacked load aborts after 16 EX cycles; waiting MOV accepted on the abort cycle
        in_valid = 1'b1; in_op = 2'b10; in_rd = 3'd6; in_regwrite = 1'b1; mem_ack = 1'b0;
        next_cycle();
        in_op = 2'b00; in_rd = 3'd5; in_rs1 = 3'd6;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("to_mem_req", {7'd0, mem_req}, 8'd1);
            chk("to_in_ready", {7'd0, in_ready}, {7'd0, (k == 16)});
            chk("to_mem_err_pre", {7'd0, mem_err}, 8'd0);
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("to_wb_valid", {7'd0, wb_valid}, 8'd1);
        chk("to_wb_we", {7'd0, wb_we}, 8'd0);
        chk("to_wb_sel", {7'd0, wb_sel}, 8'd1);
        chk("to_mem_req_drop", {7'd0, mem_req}, 8'd0);
        chk("to_mem_err", {7'd0, mem_err}, 8'd1);
        chk("to_mov_in_ex", {7'd0, ex_valid}, 8'd1);
        chk("to_mov_fwd", {7'd0, fwd_rs1}, 8'd0);
        for (int k = 0; k < 4; k++) next_cycle();
        @(negedge clk);
        chk("to_mem_err_sticky", {7'd0, mem_err}, 8'd1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("to_mem_err_clr", {7'd0, mem_err}, 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
